gate_response_checker: RTL and testbench
========================================

Name: gate_response_checker

Overview:
Synthesizable response checker for 2-input logic-gate DUTs; the receiving end of the gate stimulus interface.
- Accepts each applied {a,b} vector through a valid/ready handshake.
- Waits a programmable settle time, samples the DUT output and compares it with the expected truth-table value for the selected gate.
- Accumulates pass/fail counts, records the first failing vector, and signals done after NUM_VECTORS vectors.

Parameters:
SETTLE_CYCLES, 4, clock cycles between vector acceptance and DUT sampling; legal range 1..255
NUM_VECTORS, 4, vectors checked per run; legal range 1..2^CNT_W-1
CNT_W, 8, width of the vector, pass and fail counters

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  begin run; sampled only in IDLE and DONE
gate_sel  in  3  gate selection: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 11x illegal
vec_valid  in  1  stimulus vector presented
vec_ready  out  1  checker ready to accept a vector
vec_a  in  1  stimulus input a
vec_b  in  1  stimulus input b
dut_y  in  1  DUT output under check
busy  out  1  run in progress (any state other than IDLE and DONE)
done  out  1  run complete; held until the next start or rst
cfg_err  out  1  illegal gate_sel latched at start
pass_cnt  out  CNT_W  matching samples
fail_cnt  out  CNT_W  mismatching samples
first_fail_valid  out  1  at least one mismatch has occurred this run
first_fail_vec  out  2  {a,b} of the first mismatch

Behaviour:
- Reset:
  - On rst, the FSM goes to IDLE.
  - vec_ready=0, busy=0, done=0, cfg_err=0.
  - pass_cnt=0, fail_cnt=0, first_fail_valid=0, first_fail_vec=2'b00.
  - Internal vector count=0.
  - rst in any state, including mid-SETTLE, aborts the run immediately with these values.
- FSM states: IDLE, WAIT_VEC, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start=1, latch gate_sel, clear counters, first_fail_valid, cfg_err and the vector count.
  - Legal gate_sel: go to WAIT_VEC.
  - Illegal gate_sel: set cfg_err=1 and go to DONE; no vectors are accepted.
- WAIT_VEC:
  - vec_ready=1.
  - Transfer occurs on an edge where vec_valid&vec_ready=1. At that edge, capture {vec_a,vec_b}, load the settle counter with SETTLE_CYCLES-1 and go to SETTLE.
  - vec_valid=0: remain in WAIT_VEC indefinitely, counters unchanged.
- SETTLE:
  - vec_ready=0.
  - Decrement the settle counter each cycle. When it reaches 0, go to SAMPLE.
  - The FSM spends exactly SETTLE_CYCLES cycles in SETTLE.
- SAMPLE:
  - One cycle long; vec_ready=0.
  - Compare dut_y with expected = f(gate_sel_latched, a, b).
  - Match: pass_cnt+1. Mismatch: fail_cnt+1.
  - If first_fail_valid=0 on a mismatch, set first_fail_valid=1 and first_fail_vec={a,b}.
  - Vector count+1. If the new count equals NUM_VECTORS, go to DONE; otherwise go to WAIT_VEC.
- Timing:
  - Acceptance edge = E.
  - dut_y is sampled at edge E+SETTLE_CYCLES+1.
  - Counters show the updated values after that same edge.
  - Minimum vector spacing is SETTLE_CYCLES+2 cycles.
- Counter saturation: pass_cnt and fail_cnt saturate at 2^CNT_W-1 and never wrap.
- DONE:
  - done=1, busy=0, vec_ready=0.
  - Outputs are held stable.
  - start=1 restarts the run exactly as from IDLE, including clearing the counters and re-latching gate_sel.
- start is ignored in WAIT_VEC, SETTLE and SAMPLE.
- gate_sel changes after start have no effect until the next start.
- vec_a, vec_b and vec_valid are don't-care outside WAIT_VEC.
- dut_y is don't-care outside SAMPLE.

Test Plan:
- Correct OR DUT, gate_sel=001: vectors 00,01,10,11 with dut_y=a|b. Required: pass_cnt=4, fail_cnt=0, first_fail_valid=0, done=1.
- Faulty DUT implementing AND, gate_sel=001: vectors 00,01,10,11. Required: pass_cnt=2, fail_cnt=2, first_fail_vec=01, done=1.
- gate_sel=110, start pulse. Required: cfg_err=1 and done=1 one edge later; vec_ready never asserts.
- Timing check with SETTLE_CYCLES=4:
  - Hold vec_valid=0 for 10 cycles in WAIT_VEC: counters stay 0 and vec_ready stays 1.
  - Then accept at edge E with dut_y glitching wrong until E+4 and correct at E+5: the vector counts as a pass.
- Assert rst for one cycle during SETTLE of vector 2. Required: all outputs return to reset values and the FSM returns to IDLE; a subsequent fresh run of 4 vectors passes fully.
- Restart from DONE with fail_cnt=2: start pulse with gate_sel=100 (XOR). Required: counters clear, first_fail_valid=0, new run checks XOR; start asserted during SETTLE is ignored.

Source files
------------

// File: rtl/gate_response_checker.sv
// gate_response_checker: handshakes {a,b} vectors, waits a settle time, then scores a 2-input gate DUT's output against its truth table.
module gate_response_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             vec_a,
  input  logic             vec_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec
);
  typedef enum logic [2:0] {IDLE, WAIT_VEC, SETTLE, SAMPLE, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VECTORS - 1);
  state_t           state;
  logic [2:0]       sel;
  logic [1:0]       vec;
  logic [7:0]       settle;
  logic [CNT_W-1:0] vcnt;
  logic             expected;
  // XOR family lives at sel[2]; the low bit inverts there, sel[1] inverts AND/OR
  always_comb expected = (sel[2] ? ^vec : sel[0] ? |vec : &vec) ^ (sel[2] ? sel[0] : sel[1]);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cfg_err <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec <= 2'b00;
      vcnt <= '0;
      settle <= '0;
      sel <= '0;
      vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          sel <= gate_sel;
          pass_cnt <= '0;
          fail_cnt <= '0;
          first_fail_valid <= 1'b0;
          first_fail_vec <= 2'b00;
          vcnt <= '0;
          cfg_err <= &gate_sel[2:1];
          done <= &gate_sel[2:1];
          busy <= ~&gate_sel[2:1];
          vec_ready <= ~&gate_sel[2:1];
          state <= &gate_sel[2:1] ? DONE : WAIT_VEC;
        end
        WAIT_VEC: if (vec_valid) begin
          vec <= {vec_a, vec_b};
          settle <= 8'(SETTLE_CYCLES - 1);
          vec_ready <= 1'b0;
          state <= SETTLE;
        end
        SETTLE: begin
          settle <= settle - 8'd1;
          state <= settle == 8'd0 ? SAMPLE : SETTLE;
        end
        SAMPLE: begin
          if (dut_y == expected) pass_cnt <= pass_cnt + CNT_W'(pass_cnt != '1);
          else begin
            fail_cnt <= fail_cnt + CNT_W'(fail_cnt != '1);
            first_fail_valid <= 1'b1;
            if (!first_fail_valid) first_fail_vec <= vec;
          end
          vcnt <= vcnt + CNT_W'(1);
          done <= vcnt == LAST;
          busy <= vcnt != LAST;
          vec_ready <= vcnt != LAST;
          state <= vcnt == LAST ? DONE : WAIT_VEC;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: drives directed and random runs, scoring the checker against a transaction-level truth-table model every cycle.
module tb_gate_response_checker;
  localparam int S = 4;
  localparam int NV = 4;
  localparam int W = 8;
  logic clk = 0, rst = 1, start = 0, vec_valid = 0, vec_a = 0, vec_b = 0, dut_y = 0;
  logic [2:0] gate_sel = 0;
  logic vec_ready, busy, done, cfg_err, first_fail_valid;
  logic [W-1:0] pass_cnt, fail_cnt;
  logic [1:0] first_fail_vec;
  int compared = 0, mismatched = 0;
  bit chk_en = 0;
  bit m_ready, m_busy, m_done, m_cfg, m_ffv;
  int m_pass, m_fail, m_n;
  logic [1:0] m_ffvec;
  logic [2:0] m_sel;

  gate_response_checker #(.SETTLE_CYCLES(S), .NUM_VECTORS(NV), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_a(vec_a), .vec_b(vec_b), .dut_y(dut_y), .busy(busy),
    .done(done), .cfg_err(cfg_err), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;

  function automatic bit truth(input logic [2:0] s, input bit a, input bit b);
    logic [3:0] tt;
    tt = s == 0 ? 4'b1000 : s == 1 ? 4'b1110 : s == 2 ? 4'b0111 :
         s == 3 ? 4'b0001 : s == 4 ? 4'b0110 : 4'b1001;
    return tt[{a, b}];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("vec_ready", vec_ready, m_ready);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("cfg_err", cfg_err, m_cfg);
    chk("pass_cnt", pass_cnt, m_pass);
    chk("fail_cnt", fail_cnt, m_fail);
    chk("first_fail_valid", first_fail_valid, m_ffv);
    chk("first_fail_vec", first_fail_vec, m_ffvec);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    {m_ready, m_busy, m_done, m_cfg, m_ffv} = '0;
    m_pass = 0; m_fail = 0; m_n = 0; m_ffvec = 0;
  endtask

  task automatic do_start(input logic [2:0] sel);
    gate_sel = sel;
    start = 1;
    tick;
    start = 0;
    gate_sel = 3'($urandom);
    m_sel = sel; m_pass = 0; m_fail = 0; m_n = 0; m_ffv = 0; m_ffvec = 0;
    m_cfg = sel[2:1] == 2'b11;
    m_done = m_cfg; m_busy = !m_cfg; m_ready = !m_cfg;
  endtask

  // dut_y is held wrong through edge E+S and correct only for the sampling edge E+S+1
  task automatic send(input bit a, input bit b, input bit y, input int gap, input bit abort, input bit noise);
    repeat (gap) tick;
    vec_valid = 1; vec_a = a; vec_b = b; dut_y = ~y;
    tick;
    m_ready = 0;
    vec_valid = 0;
    for (int i = 0; i < S; i++) begin
      if (noise) begin
        vec_valid = 1'($urandom); vec_a = 1'($urandom); vec_b = 1'($urandom); start = 1'($urandom);
      end
      if (abort && i == 1) begin
        rst = 1; start = 0; vec_valid = 0;
        tick;
        rst = 0;
        model_reset;
        return;
      end
      tick;
    end
    vec_valid = 0; start = 0; dut_y = y;
    tick;
    if (y == truth(m_sel, a, b)) m_pass = m_pass < 2**W - 1 ? m_pass + 1 : m_pass;
    else begin
      m_fail = m_fail < 2**W - 1 ? m_fail + 1 : m_fail;
      if (!m_ffv) m_ffvec = {a, b};
      m_ffv = 1;
    end
    m_n++;
    if (m_n == NV) begin m_done = 1; m_busy = 0; end
    else m_ready = 1;
  endtask

  initial begin
    model_reset;
    tick;
    chk_en = 1;
    tick;
    chk("lit_reset_pass", pass_cnt, 0);
    chk("lit_reset_ready", vec_ready, 0);
    rst = 0;
    tick;
    // correct OR DUT
    do_start(3'b001);
    for (int v = 0; v < 4; v++) send(v[1], v[0], v[1] | v[0], 0, 0, 0);
    chk("lit_or_pass", pass_cnt, 4);
    chk("lit_or_fail", fail_cnt, 0);
    chk("lit_or_ffv", first_fail_valid, 0);
    chk("lit_or_done", done, 1);
    // AND-implementing DUT checked as OR
    do_start(3'b001);
    for (int v = 0; v < 4; v++) send(v[1], v[0], v[1] & v[0], 1, 0, 0);
    chk("lit_and_pass", pass_cnt, 2);
    chk("lit_and_fail", fail_cnt, 2);
    chk("lit_and_ffvec", first_fail_vec, 2'b01);
    chk("lit_and_done", done, 1);
    // restart from DONE as XOR, with start noise during SETTLE
    do_start(3'b100);
    chk("lit_xor_clear_fail", fail_cnt, 0);
    chk("lit_xor_clear_ffv", first_fail_valid, 0);
    for (int v = 0; v < 4; v++) send(v[1], v[0], v[1] ^ v[0], 0, 0, 1);
    chk("lit_xor_pass", pass_cnt, 4);
    chk("lit_xor_busy", busy, 0);
    // illegal gate select
    do_start(3'b110);
    chk("lit_cfg_err", cfg_err, 1);
    chk("lit_cfg_done", done, 1);
    repeat (3) tick;
    // long stall then a glitching dut_y that settles in time
    do_start(3'b001);
    repeat (10) tick;
    chk("lit_stall_ready", vec_ready, 1);
    chk("lit_stall_pass", pass_cnt, 0);
    send(1, 0, 1, 0, 0, 0);
    chk("lit_glitch_pass", pass_cnt, 1);
    for (int v = 0; v < 3; v++) send(v[1], v[0], v[1] | v[0], 0, 0, 0);
    // reset during SETTLE of vector 2, then a clean run
    do_start(3'b000);
    send(1, 1, 1, 0, 0, 0);
    send(0, 1, 0, 0, 1, 0);
    chk("lit_abort_pass", pass_cnt, 0);
    chk("lit_abort_busy", busy, 0);
    tick;
    do_start(3'b000);
    for (int v = 0; v < 4; v++) send(v[1], v[0], v[1] & v[0], 0, 0, 0);
    chk("lit_fresh_pass", pass_cnt, 4);
    // randomized runs
    for (int r = 0; r < 40; r++) begin
      do_start(3'($urandom_range(0, 7)));
      if (!m_cfg) for (int v = 0; v < NV; v++) begin
        bit a, b, y, ab;
        a = 1'($urandom); b = 1'($urandom);
        y = $urandom_range(0, 3) == 0 ? !truth(m_sel, a, b) : truth(m_sel, a, b);
        ab = v == 1 && $urandom_range(0, 9) == 0;
        send(a, b, y, $urandom_range(0, 2), ab, 1);
        if (ab) break;
      end
      repeat ($urandom_range(0, 3)) tick;
    end
    tick;
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
